host_interface_burst: RTL

- Parametrised successor of the GPIF host interface: decodes the firmware state code and the ctl strobes into device-interface register transactions.
- Adds configurable data and address widths, burst read/write with address auto-increment, a read-ready timeout with a sticky error flag, and a host-controlled di_reset pulse.
- Sits between the pad-level tristate buffer at top level and the device register bus. The tristate itself stays outside this block.

---
 rtl/host_interface_burst_if.sv | 44 ++++
 rtl/host_interface_burst.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/host_interface_burst_if.sv
// host_interface_burst_if
//   Bundles the host-side (GPIF pad buffer) and device-side (register bus)
//   signals of host_interface_burst.
//   modport master : the bridge itself (drives pad data/oe/rdy and di_* bus)
//   modport slave  : the environment (GPIF host + device register file)
//   Signals:
//     ctl, state, hi_data_in           host -> bridge
//     hi_data_out, hi_data_oe, rdy     bridge -> host pad buffer
//     di_ep_addr, di_reg_addr,
//     di_reg_data_in, di_write,
//     di_read, di_reset, timeout_err   bridge -> device
//     di_reg_data_out, rdwr_ready      device -> bridge
interface host_interface_burst_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic [2:0]            ctl;
    logic [3:0]            state;
    logic [DATA_WIDTH-1:0] hi_data_in;
    logic [DATA_WIDTH-1:0] hi_data_out;
    logic                  hi_data_oe;
    logic                  rdy;
    logic [ADDR_WIDTH-1:0] di_ep_addr;
    logic [ADDR_WIDTH-1:0] di_reg_addr;
    logic [DATA_WIDTH-1:0] di_reg_data_in;
    logic [DATA_WIDTH-1:0] di_reg_data_out;
    logic                  di_write;
    logic                  di_read;
    logic                  di_reset;
    logic                  rdwr_ready;
    logic                  timeout_err;

    modport master (
        input  ctl, state, hi_data_in, di_reg_data_out, rdwr_ready,
        output hi_data_out, hi_data_oe, rdy, di_ep_addr, di_reg_addr,
               di_reg_data_in, di_write, di_read, di_reset, timeout_err
    );

    modport slave (
        output ctl, state, hi_data_in, di_reg_data_out, rdwr_ready,
        input  hi_data_out, hi_data_oe, rdy, di_ep_addr, di_reg_addr,
               di_reg_data_in, di_write, di_read, di_reset, timeout_err
    );
endinterface

// File: rtl/host_interface_burst.sv
// host_interface_burst
//   Decodes the firmware op code (state) and the ctl[1] strobe into
//   device register transactions: endpoint/register address set-up,
//   burst writes and reads with optional address auto-increment, a read
//   timeout with sticky error flag, and a device reset pulse.
//   Ports:
//     if_clock : interface clock (single domain)
//     reset    : synchronous, active-high reset
//     bus      : host_interface_burst_if.master (host pad side + device bus)
module host_interface_burst #(
    parameter int          DATA_WIDTH     = 16,
    parameter int          ADDR_WIDTH     = 16,
    parameter bit          AUTO_INC       = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TIMEOUT_VALUE  = 16'hDEAD
) (
    input  logic                   if_clock,
    input  logic                   reset,
    host_interface_burst_if.master bus
);
    localparam logic [3:0] OP_SETEP     = 4'd1;
    localparam logic [3:0] OP_SETREG    = 4'd2;
    localparam logic [3:0] OP_RDDATA    = 4'd4;
    localparam logic [3:0] OP_RESETRVAL = 4'd5;
    localparam logic [3:0] OP_WRDATA    = 4'd7;

    localparam logic [15:0]           TIMER_LAST   = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] TIMEOUT_DATA = DATA_WIDTH'(TIMEOUT_VALUE);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_HOLD} rd_state_t;

    // Input pipeline
    logic [3:0]            state_q, state_q_d;
    logic [2:0]            ctl_q, ctl_q_d;
    logic [DATA_WIDTH-1:0] data_q, data_q_d;
    logic                  strobe_reg;

    // Architectural state
    rd_state_t             rd_state_reg, rd_state_next;
    logic [15:0]           timer_reg, timer_next;
    logic                  set_done_reg, set_done_next;
    logic [DATA_WIDTH-1:0] hi_data_out_reg, hi_data_out_next;
    logic                  hi_data_oe_reg, hi_data_oe_next;
    logic                  rdy_reg, rdy_next;
    logic [ADDR_WIDTH-1:0] ep_addr_reg, ep_addr_next;
    logic [ADDR_WIDTH-1:0] reg_addr_reg, reg_addr_next;
    logic [DATA_WIDTH-1:0] wr_data_reg, wr_data_next;
    logic                  di_write_reg, di_write_next;
    logic                  di_read_reg, di_read_next;
    logic                  di_reset_reg, di_reset_next;
    logic                  timeout_err_reg, timeout_err_next;

    logic                  op_change;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] data_ext;
    logic                  unused_bits;

    assign op_change = (state_q != state_q_d);
    // Zero-extend so the address slice is legal for any width combination.
    assign data_ext  = {{ADDR_WIDTH{1'b0}}, data_q_d};
    assign unused_bits = ^{ctl_q[2], ctl_q[0], ctl_q_d[2], ctl_q_d[0],
                           data_ext[ADDR_WIDTH+DATA_WIDTH-1:ADDR_WIDTH]};

    always_ff @(posedge if_clock) begin
        if (reset) begin
            state_q         <= '0;
            state_q_d       <= '0;
            ctl_q           <= '0;
            ctl_q_d         <= '0;
            data_q          <= '0;
            data_q_d        <= '0;
            strobe_reg      <= 1'b0;
            rd_state_reg    <= IDLE;
            timer_reg       <= '0;
            set_done_reg    <= 1'b0;
            hi_data_out_reg <= '0;
            hi_data_oe_reg  <= 1'b0;
            rdy_reg         <= 1'b0;
            ep_addr_reg     <= '0;
            reg_addr_reg    <= '0;
            wr_data_reg     <= '0;
            di_write_reg    <= 1'b0;
            di_read_reg     <= 1'b0;
            di_reset_reg    <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_q         <= bus.state;
            state_q_d       <= state_q;
            ctl_q           <= bus.ctl;
            ctl_q_d         <= ctl_q;
            data_q          <= bus.hi_data_in;
            data_q_d        <= data_q;
            // Registering the rise aligns the strobe with data_q_d and
            // gives the two-edge strobe-to-pulse latency.
            strobe_reg      <= ctl_q[1] & ~ctl_q_d[1];
            rd_state_reg    <= rd_state_next;
            timer_reg       <= timer_next;
            set_done_reg    <= set_done_next;
            hi_data_out_reg <= hi_data_out_next;
            hi_data_oe_reg  <= hi_data_oe_next;
            rdy_reg         <= rdy_next;
            ep_addr_reg     <= ep_addr_next;
            reg_addr_reg    <= reg_addr_next;
            wr_data_reg     <= wr_data_next;
            di_write_reg    <= di_write_next;
            di_read_reg     <= di_read_next;
            di_reset_reg    <= di_reset_next;
            timeout_err_reg <= timeout_err_next;
        end
    end

    always_comb begin
        rd_state_next    = rd_state_reg;
        timer_next       = timer_reg;
        set_done_next    = set_done_reg;
        hi_data_out_next = hi_data_out_reg;
        hi_data_oe_next  = hi_data_oe_reg;
        rdy_next         = rdy_reg;
        ep_addr_next     = ep_addr_reg;
        reg_addr_next    = reg_addr_reg;
        wr_data_next     = wr_data_reg;
        di_write_next    = 1'b0;
        di_read_next     = 1'b0;
        di_reset_next    = 1'b0;
        timeout_err_next = timeout_err_reg;

        // Post-write increment lands the cycle after the di_write pulse,
        // even if the op is being aborted in that same cycle.
        if (AUTO_INC && di_write_reg) begin
            reg_addr_next = reg_addr_reg + ADDR_WIDTH'(1);
        end

        if (op_change) begin
            rd_state_next   = IDLE;
            hi_data_oe_next = 1'b0;
            rdy_next        = 1'b0;
            set_done_next   = 1'b0;
        end else begin
            if (rd_state_reg == RD_WAIT) begin
                timer_next = timer_reg + 16'd1;
                // Ready takes priority over a coincident timeout.
                if (bus.rdwr_ready) begin
                    hi_data_out_next = bus.di_reg_data_out;
                    rdy_next         = 1'b1;
                    hi_data_oe_next  = 1'b1;
                    rd_state_next    = RD_HOLD;
                    if (AUTO_INC) reg_addr_next = reg_addr_reg + ADDR_WIDTH'(1);
                end else if (timer_reg == TIMER_LAST) begin
                    hi_data_out_next = TIMEOUT_DATA;
                    rdy_next         = 1'b1;
                    hi_data_oe_next  = 1'b1;
                    timeout_err_next = 1'b1;
                    rd_state_next    = RD_HOLD;
                    if (AUTO_INC) reg_addr_next = reg_addr_reg + ADDR_WIDTH'(1);
                end
            end

            if (strobe_reg) begin
                case (state_q_d)
                    OP_SETEP: begin
                        if (!set_done_reg) begin
                            ep_addr_next  = data_ext[ADDR_WIDTH-1:0];
                            set_done_next = 1'b1;
                        end
                    end
                    OP_SETREG: begin
                        if (!set_done_reg) begin
                            reg_addr_next = data_ext[ADDR_WIDTH-1:0];
                            set_done_next = 1'b1;
                        end
                    end
                    OP_WRDATA: begin
                        wr_data_next  = data_q_d;
                        di_write_next = 1'b1;
                    end
                    OP_RESETRVAL: begin
                        di_reset_next    = 1'b1;
                        timeout_err_next = 1'b0;
                    end
                    OP_RDDATA: begin
                        if (rd_state_reg != RD_WAIT) begin
                            di_read_next    = 1'b1;
                            rdy_next        = 1'b0;
                            hi_data_oe_next = 1'b0;
                            timer_next      = '0;
                            rd_state_next   = RD_WAIT;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.hi_data_out    = hi_data_out_reg;
    assign bus.hi_data_oe     = hi_data_oe_reg;
    assign bus.rdy            = rdy_reg;
    assign bus.di_ep_addr     = ep_addr_reg;
    assign bus.di_reg_addr    = reg_addr_reg;
    assign bus.di_reg_data_in = wr_data_reg;
    assign bus.di_write       = di_write_reg;
    assign bus.di_read        = di_read_reg;
    assign bus.di_reset       = di_reset_reg;
    assign bus.timeout_err    = timeout_err_reg;
endmodule
